// File: rtl/hamming_secded_codec.sv
`timescale 1ns/1ps
// hamming_secded_codec
//   Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready
//   streams on both sides and saturating error-event counters.
//
//   Codeword layout: cw[i] is Hamming position i (1..N). cw[0] is the
//   overall parity. Check bit Pk (k = 2^j) sits at position k. Data bits
//   fill the remaining positions in ascending order, so data bit 0 is at
//   position 3.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_mode               0 = encode, 1 = decode
//   in_data [CW-1:0]      encode: data in [DATA_W-1:0]; decode: codeword
//   out_valid/out_ready   output handshake
//   out_mode              mode of the presented result
//   out_data [CW-1:0]     encode: codeword; decode: corrected data (zero-extended)
//   err_single/err_double corrected / uncorrectable decode result
//   syndrome [R-1:0]      raw decode syndrome (zero for encode)
//   cnt_clr               synchronous clear of both counters
//   corr_cnt/uncorr_cnt   saturating event counters
module hamming_secded_codec #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1, valid for DATA_W in 4..64.
    localparam int R  = (DATA_W <= 4)  ? 3 :
                        (DATA_W <= 11) ? 4 :
                        (DATA_W <= 26) ? 5 :
                        (DATA_W <= 57) ? 6 : 7,
    localparam int N  = DATA_W + R,
    localparam int CW = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CW-1:0]     in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CW-1:0]     out_data,
    output logic              err_single,
    output logic              err_double,
    output logic [R-1:0]      syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [R-1:0] N_R = R'(N);

    // Hamming position of data bit k: the k-th non-power-of-two index >= 1.
    function automatic int data_pos(input int k);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) res = i;
                cnt++;
            end
        end
        return res;
    endfunction

    // Mask of positions 1..N whose index has bit j set.
    function automatic logic [CW-1:0] pos_mask(input int j);
        logic [CW-1:0] m;
        m = '0;
        for (int i = 1; i <= N; i++) begin
            if (((i >> j) & 1) != 0) m = m | (CW'(1) << i);
        end
        return m;
    endfunction

    // Pipeline registers
    logic              r_s1_valid, r_s1_mode;
    logic [CW-1:0]     r_s1_data;
    logic              r_s2_valid, r_s2_mode, r_s2_single, r_s2_double;
    logic [CW-1:0]     r_s2_data;
    logic [R-1:0]      r_s2_syn;
    logic [CNT_W-1:0]  r_corr, r_uncorr;

    // Combinational datapath between the stages
    logic [CW-1:0]     w_enc_raw;    // data placed, check bits and parity zero
    logic [CW-1:0]     w_enc_cw;     // complete codeword
    logic [R-1:0]      w_enc_chk;
    logic [R-1:0]      w_dec_syn;
    logic              w_dec_par;
    logic [CW-1:0]     w_flip;
    logic [CW-1:0]     w_fixed;
    logic [DATA_W-1:0] w_dec_data;
    logic [CW-1:0]     w_res_data;
    logic              w_res_single, w_res_double;
    logic [R-1:0]      w_res_syn;
    logic              w_s1_adv, w_s2_adv, w_fire;

    assign w_enc_raw[0] = 1'b0;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
        localparam int P = data_pos(gi);
        assign w_enc_raw[P]   = r_s1_data[gi];
        assign w_enc_cw[P]    = r_s1_data[gi];
        assign w_dec_data[gi] = w_fixed[P];
    end

    for (genvar gi = 0; gi < R; gi++) begin : g_check
        localparam int            K    = 1 << gi;
        localparam logic [CW-1:0] MASK = pos_mask(gi);
        assign w_enc_raw[K]  = 1'b0;
        // With check positions zero, the syndrome of the raw word is
        // exactly the check-bit vector.
        assign w_enc_chk[gi] = ^(w_enc_raw & MASK);
        assign w_enc_cw[K]   = w_enc_chk[gi];
        assign w_dec_syn[gi] = ^(r_s1_data & MASK);
    end

    assign w_enc_cw[0] = (^w_enc_raw[CW-1:1]) ^ (^w_enc_chk);

    assign w_dec_par = ^r_s1_data;
    // p=1 with s=0 flips cw[0], which leaves the data untouched.
    assign w_flip    = (w_dec_par && (w_dec_syn <= N_R)) ? (CW'(1) << w_dec_syn) : '0;
    assign w_fixed   = r_s1_data ^ w_flip;

    always_comb begin
        w_res_data   = w_enc_cw;
        w_res_single = 1'b0;
        w_res_double = 1'b0;
        w_res_syn    = '0;
        if (r_s1_mode) begin
            w_res_data = {{(CW-DATA_W){1'b0}}, w_dec_data};
            w_res_syn  = w_dec_syn;
            if (w_dec_par) begin
                if (w_dec_syn <= N_R) w_res_single = 1'b1;
                else                  w_res_double = 1'b1;
            end else if (w_dec_syn != '0) begin
                w_res_double = 1'b1;
            end
        end
    end

    // A stage may load when it is empty or its word leaves this cycle.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_fire   = r_s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= 1'b0;
            r_s1_data   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_mode   <= 1'b0;
            r_s2_data   <= '0;
            r_s2_single <= 1'b0;
            r_s2_double <= 1'b0;
            r_s2_syn    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_mode <= in_mode;
                    r_s1_data <= in_data;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_mode   <= r_s1_mode;
                    r_s2_data   <= w_res_data;
                    r_s2_single <= w_res_single;
                    r_s2_double <= w_res_double;
                    r_s2_syn    <= w_res_syn;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (cnt_clr) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (w_fire && r_s2_mode) begin
            if (r_s2_single && (r_corr != {CNT_W{1'b1}}))
                r_corr <= r_corr + 1'b1;
            if (r_s2_double && (r_uncorr != {CNT_W{1'b1}}))
                r_uncorr <= r_uncorr + 1'b1;
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_valid;
    assign out_mode   = r_s2_mode;
    assign out_data   = r_s2_data;
    assign err_single = r_s2_single;
    assign err_double = r_s2_double;
    assign syndrome   = r_s2_syn;
    assign corr_cnt   = r_corr;
    assign uncorr_cnt = r_uncorr;

endmodule

// File: tb/tb_hamming_secded_codec.sv
`timescale 1ns/1ps
module tb_hamming_secded_codec;

    localparam int DW = 8;
    localparam int CNTW = 2;
    localparam int RR = 4;
    localparam int NN = 12;
    localparam int CWW = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_mode = 1'b0;
    logic [CWW-1:0]  in_data = '0;
    logic            out_ready = 1'b0;
    logic            cnt_clr = 1'b0;
    logic            in_ready, out_valid, out_mode, err_single, err_double;
    logic [CWW-1:0]  out_data;
    logic [RR-1:0]   syndrome;
    logic [CNTW-1:0] corr_cnt, uncorr_cnt;

    hamming_secded_codec #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .err_single(err_single), .err_double(err_double), .syndrome(syndrome),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           mode;
        logic [CWW-1:0] data;
        logic           sgl;
        logic           dbl;
        logic [RR-1:0]  syn;
    } res_t;

    typedef struct {
        logic           mode;
        logic [CWW-1:0] din;
        res_t           exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    res_t exp_q[$];
    int hs_log[$];
    int cyc = 0;
    logic [1:0] m_corr = '0, m_uncorr = '0;
    logic hold_pending = 1'b0;
    logic [19:0] held;
    logic done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (from the code definition) ----------------
    function automatic logic [CWW-1:0] m_encode(input logic [DW-1:0] d);
        logic [CWW-1:0] cw;
        logic par;
        int k;
        cw = '0;
        k = 0;
        for (int p = 1; p <= NN; p++)
            if ($countones(p) != 1) begin cw[p] = d[k]; k++; end
        for (int j = 0; j < RR; j++) begin
            par = 1'b0;
            for (int p = 1; p <= NN; p++)
                if ((p & (1 << j)) != 0 && p != (1 << j)) par ^= cw[p];
            cw[1 << j] = par;
        end
        cw[0] = ^cw[CWW-1:1];
        return cw;
    endfunction

    function automatic logic [DW-1:0] m_extract(input logic [CWW-1:0] cw);
        logic [DW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p <= NN; p++)
            if ($countones(p) != 1) begin d[k] = cw[p]; k++; end
        return d;
    endfunction

    // Decode by search: a word is clean if it re-encodes to itself; a single
    // error exists if exactly some one-bit flip makes it clean.
    function automatic res_t m_decode(input logic [CWW-1:0] cw);
        res_t r;
        logic [CWW-1:0] t, fixed;
        logic found;
        r.mode = 1'b1; r.sgl = 1'b0; r.dbl = 1'b0; r.syn = '0;
        for (int p = 1; p <= NN; p++) if (cw[p]) r.syn ^= 4'(p);
        found = 1'b0;
        fixed = cw;
        if (m_encode(m_extract(cw)) == cw) begin
            r.data = {5'b0, m_extract(cw)};
        end else begin
            for (int b = 0; b < CWW; b++) begin
                t = cw;
                t[b] = ~t[b];
                if (!found && m_encode(m_extract(t)) == t) begin found = 1'b1; fixed = t; end
            end
            if (found) begin r.sgl = 1'b1; r.data = {5'b0, m_extract(fixed)}; end
            else       begin r.dbl = 1'b1; r.data = {5'b0, m_extract(cw)}; end
        end
        return r;
    endfunction

    function automatic res_t m_model(input logic m, input logic [CWW-1:0] din);
        res_t r;
        if (m) return m_decode(din);
        r.mode = 1'b0; r.data = m_encode(din[DW-1:0]); r.sgl = 1'b0; r.dbl = 1'b0; r.syn = '0;
        return r;
    endfunction

    function automatic vec_t mk(input logic m, input logic [CWW-1:0] din, input logic [CWW-1:0] ed,
                                input logic s, input logic d, input logic [RR-1:0] syn);
        vec_t v;
        v.mode = m; v.din = din;
        v.exp.mode = m; v.exp.data = ed; v.exp.sgl = s; v.exp.dbl = d; v.exp.syn = syn;
        return v;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        res_t e;
        logic e_ok;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            hold_pending = 1'b0;
            m_corr = '0;
            m_uncorr = '0;
        end else begin
            chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
            if (hold_pending && out_valid)
                chk("hold_stable", 32'({out_mode, out_data, err_single, err_double, syndrome}), 32'(held));
            e_ok = 1'b0;
            if (out_valid && out_ready) begin
                hs_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_output: got data %0h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    e_ok = 1'b1;
                    chk("result", 32'({out_mode, out_data, err_single, err_double, syndrome}),
                        32'({e.mode, e.data, e.sgl, e.dbl, e.syn}));
                    $display("xfer mode=%0d data=%h single=%0d double=%0d syn=%0d (exp data=%h)",
                             out_mode, out_data, err_single, err_double, syndrome, e.data);
                end
            end
            if (cnt_clr) begin
                m_corr = '0; m_uncorr = '0;
            end else if (e_ok && e.mode) begin
                if (e.sgl && m_corr != 2'd3) m_corr++;
                if (e.dbl && m_uncorr != 2'd3) m_uncorr++;
            end
            hold_pending = out_valid && !out_ready;
            held = {out_mode, out_data, err_single, err_double, syndrome};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic m, input logic [CWW-1:0] d, input res_t e);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_data = d;
        #1;
        while (!in_ready && budget < 200) begin @(negedge clk); #1; budget++; end
        if (!in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 200) begin @(negedge clk); #2; b++; end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    vec_t vecs[14];

    initial begin
        logic [CWW-1:0] cw;
        logic [DW-1:0] d;
        logic m;
        int b0, b1, bw;

        vecs[0]  = mk(0, 13'h0001, 13'h000F, 0, 0, 0);
        vecs[1]  = mk(0, 13'h1F01, 13'h000F, 0, 0, 0);
        vecs[2]  = mk(0, 13'h00FF, 13'h1EEE, 0, 0, 0);
        vecs[3]  = mk(0, 13'h00A5, 13'h144E, 0, 0, 0);
        vecs[4]  = mk(1, 13'h000F, 13'h0001, 0, 0, 0);
        vecs[5]  = mk(1, 13'h004F, 13'h0001, 1, 0, 6);
        vecs[6]  = mk(1, 13'h024F, 13'h0015, 0, 1, 15);
        vecs[7]  = mk(1, 13'h1009, 13'h0081, 0, 1, 15);
        vecs[8]  = mk(1, 13'h1EEE, 13'h00FF, 0, 0, 0);
        vecs[9]  = mk(1, 13'h1EEF, 13'h00FF, 1, 0, 0);
        vecs[10] = mk(1, 13'h1AEE, 13'h00FF, 1, 0, 10);
        vecs[11] = mk(1, 13'h0EEE, 13'h00FF, 1, 0, 12);
        vecs[12] = mk(1, 13'h0000, 13'h0000, 0, 0, 0);
        vecs[13] = mk(1, 13'h0001, 13'h0000, 1, 0, 0);

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {out_mode, out_data, err_single, err_double, syndrome}, 0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_out_valid", out_valid, 0);

        // Table-driven directed vectors
        foreach (vecs[i]) send(vecs[i].mode, vecs[i].din, vecs[i].exp);
        drain();

        // Back-to-back encodes under backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        send(0, 13'h0001, m_model(0, 13'h0001));
        send(0, 13'h0002, m_model(0, 13'h0002));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mode = 1'b0; in_data = 13'h0003;
            #1 chk("in_ready_full", in_ready, 0);
        end
        @(posedge clk); #1;
        hs_log.delete();
        out_ready = 1'b1;
        send(0, 13'h0003, m_model(0, 13'h0003));
        send(0, 13'h0004, m_model(0, 13'h0004));
        drain();
        chk("b2b_count", hs_log.size(), 4);
        for (int i = 1; i < hs_log.size(); i++)
            chk("b2b_one_per_cycle", hs_log[i] - hs_log[i-1], 1);

        // Counter saturation and clear-wins
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk); #1 chk("cnt_cleared", corr_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            cw = m_encode(DW'($urandom));
            bw = $urandom_range(0, CWW-1);
            cw[bw] = ~cw[bw];
            send(1, cw, m_model(1, cw));
        end
        drain();
        @(negedge clk); #1 chk("corr_saturated", corr_cnt, 3);
        @(posedge clk); #1 out_ready = 1'b0;
        cw = m_encode(8'h5A) ^ 13'h0010;
        send(1, cw, m_model(1, cw));
        bw = 0;
        while (!out_valid && bw < 50) begin @(negedge clk); #1; bw++; end
        chk("sat_out_valid", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1; cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        @(negedge clk); #1;
        chk("clr_wins", corr_cnt, 0);
        chk("clr_wins_q", exp_q.size(), 0);

        // Randomized traffic against the model
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    m = 1'($urandom_range(0, 1));
                    if (!m) begin
                        cw = CWW'($urandom);
                    end else begin
                        d = DW'($urandom);
                        cw = m_encode(d);
                        case ($urandom_range(0, 3))
                            1: begin b0 = $urandom_range(0, CWW-1); cw[b0] = ~cw[b0]; end
                            2: begin
                                b0 = $urandom_range(0, CWW-1);
                                b1 = (b0 + $urandom_range(1, CWW-1)) % CWW;
                                cw[b0] = ~cw[b0]; cw[b1] = ~cw[b1];
                            end
                            3: cw = CWW'($urandom);
                            default: ;
                        endcase
                    end
                    send(m, cw, m_model(m, cw));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cnt_clr = ($urandom_range(0, 31) == 0);
                end
            end
        join
        @(posedge clk); #1 out_ready = 1'b1; cnt_clr = 1'b0;
        drain();

        // Reset while words are in flight
        send(1, 13'h004F, m_model(1, 13'h004F));
        drain();
        @(posedge clk); #1 out_ready = 1'b0;
        send(0, 13'h0005, m_model(0, 13'h0005));
        send(0, 13'h0006, m_model(0, 13'h0006));
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_counters", {corr_cnt, uncorr_cnt}, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1 chk("no_stale_word", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
